// File: rtl/sprite_mem_arb_pkg.sv
// Shared defaults, requester indices and the read-tag type for the sprite memory arbiter.
// The tag index width follows the default requester count.
package sprite_mem_arb_pkg;

    localparam int NREQ_DEF   = 3;
    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 8;
    localparam int RD_LAT_DEF = 2;

    localparam int REQ_BG   = 0;
    localparam int REQ_FIRE = 1;
    localparam int REQ_ICE  = 2;

    localparam int IDX_W = (NREQ_DEF > 1) ? $clog2(NREQ_DEF) : 1;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/sprite_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: one-hot grant, granted index and next pointer.
// With SPRITE_MEM_ARB_PRIO0_EN, requester 0 wins outright and the pointer rotates over 1..NREQ-1.
module rr_picker
    import sprite_mem_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = IDX_W
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx,
    output logic [PW-1:0]   nxt_ptr
);

`ifdef SPRITE_MEM_ARB_PRIO0_EN
    localparam int WRAP = REQ_BG + 1;
`else
    localparam int WRAP = 0;
`endif

    logic [NREQ-1:0] cand;
    logic            hit;
    int              lo;
    int              sel;

    always_comb begin
        cand    = req;
        lo      = int'(ptr);
        gnt     = '0;
        gnt_idx = '0;
        nxt_ptr = ptr;
        sel     = 0;
        hit     = 1'b0;
`ifdef SPRITE_MEM_ARB_PRIO0_EN
        cand[REQ_BG] = 1'b0;
        if (lo == REQ_BG) lo = REQ_BG + 1;
`endif
        // Lowest requester overall, then overridden by the lowest one at or above the pointer.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel = i;
                hit = 1'b1;
            end
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (cand[i] && (i >= lo)) sel = i;
        end
        if (hit) begin
            for (int i = 0; i < NREQ; i++) gnt[i] = (sel == i);
            gnt_idx = PW'(sel);
            nxt_ptr = (sel == NREQ - 1) ? PW'(WRAP) : PW'(sel + 1);
        end
`ifdef SPRITE_MEM_ARB_PRIO0_EN
        if (req[REQ_BG]) begin
            gnt         = '0;
            gnt[REQ_BG] = 1'b1;
            gnt_idx     = PW'(REQ_BG);
            nxt_ptr     = ptr;
        end
`endif
    end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Sprite memory read arbiter: combinational grant to memory, RD_LAT-deep tag pipeline routes data back.
// Build option SPRITE_MEM_ARB_PRIO0_EN selects strict priority for requester 0 (inside rr_picker).
module sprite_mem_arbiter
    import sprite_mem_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NREQ-1:0]             req,
    input  logic [NREQ-1:0][ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]             gnt,
    output logic [NREQ-1:0]             rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        mem_rd,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int PW = IDX_W;

    logic [PW-1:0]     ptr_q, ptr_d;
    tag_t [RD_LAT-1:0] tag_q, tag_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [NREQ-1:0]   pick_gnt;
    logic [PW-1:0]     pick_idx;
    logic [PW-1:0]     pick_nxt;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .nxt_ptr (pick_nxt)
    );

    always_comb begin
        gnt      = Reset ? pick_gnt : '0;
        mem_rd   = |gnt;
        mem_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) mem_addr = req_addr[i];
        end
        ptr_d = mem_rd ? pick_nxt : ptr_q;

        tag_d          = '0;
        tag_d[0].valid = mem_rd;
        tag_d[0].idx   = pick_idx;
        for (int i = 1; i < RD_LAT; i++) tag_d[i] = tag_q[i-1];

        // Data arrives on the same cycle as its tag leaves the pipeline, so pass it straight through.
        rvalid  = '0;
        rdata_d = rdata_q;
        if (Reset && tag_q[RD_LAT-1].valid) begin
            for (int i = 0; i < NREQ; i++) rvalid[i] = (tag_q[RD_LAT-1].idx == PW'(i));
            rdata_d = mem_rdata;
        end
        rdata = Reset ? rdata_d : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ptr_q   <= '0;
            tag_q   <= '0;
            rdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            tag_q   <= tag_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
